// File: rtl/ro_puf_reader.sv
// Ring-oscillator PUF reader: steps NBITS challenges onto the oscillator
// select lines, counts sampled rising edges of both selected oscillators over
// a fixed window, and packs one "A faster than B" bit per challenge.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start; outputs hold the last completed result
// S_SETTLE  | challenge just changed; counters held clear while muxes settle
// S_MEASURE | counting synchronized rising edges for exactly WINDOW cycles
// S_COMPARE | one cycle: record cnt_a > cnt_b, advance or finish
// S_DONE    | word complete; resp_valid high until the consumer takes it
module ro_puf_reader #(
  parameter int CHAL_W     = 4,
  parameter int NBITS      = 8,
  parameter int CNT_W      = 16,
  parameter int WINDOW     = 1024,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CHAL_W-1:0] chal_base,
  input  logic              osc_a,
  input  logic              osc_b,
  output logic [CHAL_W-1:0] challenge,
  output logic              busy,
  output logic              resp_valid,
  output logic [NBITS-1:0]  resp_data,
  input  logic              resp_ready
);

  localparam int KW   = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int TMAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [KW-1:0]      k_q, k_d;
  logic [CHAL_W-1:0]  chal_q, chal_d;
  logic [CNT_W-1:0]   cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]   cnt_b_q, cnt_b_d;
  logic [NBITS-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic [2:0]         sync_a_q, sync_b_q;
  logic               edge_a, edge_b;

  // Oscillator synchronizers: two metastability flops plus one history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      sync_a_q <= {sync_a_q[1:0], osc_a};
      sync_b_q <= {sync_b_q[1:0], osc_b};
    end
  end

  assign edge_a = sync_a_q[1] & ~sync_a_q[2];
  assign edge_b = sync_b_q[1] & ~sync_b_q[2];

  // Controller and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      k_q     <= '0;
      chal_q  <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      k_q     <= k_d;
      chal_q  <= chal_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    k_d     = k_q;
    chal_d  = chal_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          chal_d  = chal_base;
          k_d     = '0;
          data_d  = '0;
          timer_d = TW'(SETTLE_CYC - 1);
          busy_d  = 1'b1;
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        cnt_a_d = '0;
        cnt_b_d = '0;
        if (timer_q == '0) begin
          timer_d = TW'(WINDOW - 1);
          state_d = S_MEASURE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_MEASURE: begin
        if (edge_a && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + 1'b1;
        if (edge_b && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + 1'b1;
        if (timer_q == '0) begin
          state_d = S_COMPARE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_COMPARE: begin
        data_d[k_q] = (cnt_a_q > cnt_b_q);
        if (k_q == KW'(NBITS - 1)) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 1'b1;
          chal_d  = chal_q + 1'b1;
          timer_d = TW'(SETTLE_CYC - 1);
          state_d = S_SETTLE;
        end
      end

      S_DONE: begin
        // The word settles in the register one cycle before it is offered,
        // so resp_data is already stable on the cycle resp_valid rises.
        if (!valid_q) begin
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end else if (resp_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign challenge  = chal_q;
  assign busy       = busy_q;
  assign resp_valid = valid_q;
  assign resp_data  = data_q;

endmodule

// File: tb/tb_ro_puf_reader.sv
// Bench for ro_puf_reader. Oscillators are synthesized from a global tick as
// square waves whose period depends on the challenge the DUT is driving.
// Periods used (0, 2, 4, 8, 16 clk) divide the window, so a steady waveform
// gives exactly WINDOW/period sampled edges; the reference model ranks the
// two oscillators by that nominal count.
module tb_ro_puf_reader;

  localparam int CW    = 4;
  localparam int NB    = 4;
  localparam int WIN   = 16;
  localparam int SC    = 2;
  localparam int STEP  = SC + WIN + 1;
  localparam int LAT   = NB * STEP + 1;
  localparam int S_WIN = 64;
  localparam int S_CW  = 3;
  localparam int S_LAT = NB * (SC + S_WIN + 1) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, resp_ready, busy, resp_valid;
  logic          osc_a = 1'b0, osc_b = 1'b0;
  logic [CW-1:0] chal_base, challenge;
  logic [NB-1:0] resp_data;

  logic          s_start, s_ready, s_busy, s_valid;
  logic          s_osc_a = 1'b0, s_osc_b = 1'b0;
  logic [CW-1:0] s_base, s_chal;
  logic [NB-1:0] s_data;

  int n_cmp = 0;
  int n_bad = 0;
  int tick  = 0;
  int per_a_tab[16];
  int per_b_tab[16];
  int sat_pa, sat_pb;

  logic [15:0] chal_seen;
  logic        busy_first, busy_last;

  always #5 clk = ~clk;

  ro_puf_reader #(.CHAL_W(CW), .NBITS(NB), .CNT_W(8), .WINDOW(WIN), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chal_base(chal_base),
    .osc_a(osc_a), .osc_b(osc_b), .challenge(challenge), .busy(busy),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready)
  );

  ro_puf_reader #(.CHAL_W(CW), .NBITS(NB), .CNT_W(S_CW), .WINDOW(S_WIN), .SETTLE_CYC(SC)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .chal_base(s_base),
    .osc_a(s_osc_a), .osc_b(s_osc_b), .challenge(s_chal), .busy(s_busy),
    .resp_valid(s_valid), .resp_data(s_data), .resp_ready(s_ready)
  );

  function automatic logic wave(input int per, input int t);
    if (per == 0) return 1'b0;
    return (t % per) < (per / 2);
  endfunction

  // Oscillator waveforms change away from the sampling edge
  always @(negedge clk) begin
    tick    = tick + 1;
    osc_a   = wave(per_a_tab[challenge], tick);
    osc_b   = wave(per_b_tab[challenge], tick);
    s_osc_a = wave(sat_pa, tick);
    s_osc_b = wave(sat_pb, tick);
  end

  function automatic int nom_count(input int per, input int win, input int cmax);
    if (per == 0) return 0;
    return ((win / per) > cmax) ? cmax : (win / per);
  endfunction

  function automatic logic [NB-1:0] model_word(input logic [CW-1:0] base);
    logic [NB-1:0] w;
    logic [CW-1:0] ch;
    for (int k = 0; k < NB; k++) begin
      ch   = base + CW'(k);
      w[k] = nom_count(per_a_tab[ch], WIN, 255) > nom_count(per_b_tab[ch], WIN, 255);
    end
    return w;
  endfunction

  task automatic set_tables(input int pa, input int pb);
    for (int i = 0; i < 16; i++) begin
      per_a_tab[i] = pa;
      per_b_tab[i] = pb;
    end
  endtask

  task automatic do_request(input logic [CW-1:0] base, output int lat);
    int idx;
    idx       = 0;
    lat       = -1;
    chal_seen = '0;
    @(negedge clk);
    chal_base = base;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= LAT + 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) busy_first = busy;
      if (((n - 1) % STEP) == 0 && idx < NB) begin
        chal_seen[idx*4 +: 4] = challenge;
        idx++;
      end
      if (resp_valid) begin
        lat = n;
        break;
      end
      busy_last = busy;
    end
  endtask

  task automatic do_accept();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic do_sat_request(output int lat);
    lat = -1;
    @(negedge clk);
    s_base  = 4'h0;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int n = 1; n <= S_LAT + 40; n++) begin
      @(posedge clk); #1;
      if (s_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({challenge, busy, resp_valid, resp_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_init: chal=%h busy=%b valid=%b data=%b want all 0", challenge, busy, resp_valid, resp_data);
    end
    n_cmp++;
    if ({s_chal, s_busy, s_valid, s_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_init_sat: chal=%h busy=%b valid=%b data=%b want all 0", s_chal, s_busy, s_valid, s_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_tables(4, 8);
    @(negedge clk);
    chal_base = 4'h3;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (27) @(posedge clk);
    #1;
    n_cmp++;
    if (challenge !== 4'h4 || busy !== 1'b1 || resp_data !== 4'b0001) begin
      n_bad++;
      $display("FAIL pre_reset: chal=%h busy=%b data=%b want 4 1 0001", challenge, busy, resp_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({challenge, busy, resp_valid, resp_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_midop: chal=%h busy=%b valid=%b data=%b want all 0", challenge, busy, resp_valid, resp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (resp_valid || busy || challenge != 4'h0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL after_reset_idle: activity=%b want 0", seen);
    end
  endtask

  task automatic test_basic();
    int lat;
    set_tables(4, 8);
    do_request(4'h0, lat);
    n_cmp++;
    if (lat != LAT) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
    end
    n_cmp++;
    if (resp_data !== model_word(4'h0)) begin
      n_bad++;
      $display("FAIL basic_data: got %b want %b", resp_data, model_word(4'h0));
    end
    n_cmp++;
    if (chal_seen !== 16'h3210) begin
      n_bad++;
      $display("FAIL basic_challenges: got %h want 3210", chal_seen);
    end
    n_cmp++;
    if (busy_first !== 1'b1 || busy_last !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_busy: first=%b last=%b at_valid=%b want 1 1 0", busy_first, busy_last, busy);
    end
    do_accept();
    n_cmp++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_accept: valid=%b busy=%b want 0 0", resp_valid, busy);
    end
  endtask

  task automatic test_tie();
    int lat;
    set_tables(4, 4);
    do_request(4'h7, lat);
    n_cmp++;
    if (lat != LAT || resp_data !== model_word(4'h7)) begin
      n_bad++;
      $display("FAIL tie: lat=%0d data=%b want %0d %b", lat, resp_data, LAT, model_word(4'h7));
    end
    do_accept();
  endtask

  task automatic test_wrap();
    int lat;
    set_tables(8, 0);
    per_b_tab[0] = 4;
    per_b_tab[1] = 4;
    do_request(4'hE, lat);
    n_cmp++;
    if (chal_seen !== 16'h10FE) begin
      n_bad++;
      $display("FAIL wrap_challenges: got %h want 10fe", chal_seen);
    end
    n_cmp++;
    if (lat != LAT || resp_data !== model_word(4'hE)) begin
      n_bad++;
      $display("FAIL wrap_data: lat=%0d data=%b want %0d %b", lat, resp_data, LAT, model_word(4'hE));
    end
    do_accept();
  endtask

  task automatic test_hold();
    int lat;
    logic [NB-1:0] exp;
    logic bad;
    set_tables(4, 8);
    exp = model_word(4'h5);
    do_request(4'h5, lat);
    n_cmp++;
    if (lat != LAT || resp_data !== exp) begin
      n_bad++;
      $display("FAIL hold_first: lat=%0d data=%b want %0d %b", lat, resp_data, LAT, exp);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start     = (i == 3);
      chal_base = 4'h9;
      @(posedge clk); #1;
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_data !== exp || challenge !== 4'h8 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_stable: cyc=%0d valid=%b data=%b chal=%h busy=%b want 1 %b 8 0",
                 i, resp_valid, resp_data, challenge, busy, exp);
      end
    end
    @(negedge clk);
    start      = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_handshake: valid=%b want 0", resp_valid);
    end
    @(negedge clk);
    start      = 1'b0;
    resp_ready = 1'b0;
    bad        = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || resp_valid !== 1'b0 || challenge !== 4'h8) bad = 1'b1;
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_start_ignored: busy=%b valid=%b chal=%h want 0 0 8", busy, resp_valid, challenge);
    end
  endtask

  task automatic test_random();
    int lat;
    int choices[3];
    logic [CW-1:0] base;
    logic [NB-1:0] exp;
    choices[0] = 0;
    choices[1] = 2;
    choices[2] = 8;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++) begin
        per_a_tab[i] = choices[$urandom_range(0, 2)];
        per_b_tab[i] = choices[$urandom_range(0, 2)];
      end
      base = CW'($urandom_range(0, 15));
      exp  = model_word(base);
      do_request(base, lat);
      n_cmp++;
      if (lat != LAT || resp_data !== exp) begin
        n_bad++;
        $display("FAIL random_%0d: base=%h lat=%0d data=%b want %0d %b", it, base, lat, resp_data, LAT, exp);
      end
      do_accept();
    end
  endtask

  task automatic test_saturate();
    int lat;
    logic [NB-1:0] exp;
    sat_pa = 2;
    sat_pb = 4;
    repeat (4) @(posedge clk);
    exp = {NB{nom_count(sat_pa, S_WIN, 7) > nom_count(sat_pb, S_WIN, 7)}};
    do_sat_request(lat);
    n_cmp++;
    if (lat != S_LAT || s_data !== exp) begin
      n_bad++;
      $display("FAIL saturate_tie: lat=%0d data=%b want %0d %b", lat, s_data, S_LAT, exp);
    end
    repeat (3) @(posedge clk);
    sat_pa = 4;
    sat_pb = 16;
    repeat (4) @(posedge clk);
    exp = {NB{nom_count(sat_pa, S_WIN, 7) > nom_count(sat_pb, S_WIN, 7)}};
    do_sat_request(lat);
    n_cmp++;
    if (lat != S_LAT || s_data !== exp) begin
      n_bad++;
      $display("FAIL saturate_win: lat=%0d data=%b want %0d %b", lat, s_data, S_LAT, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    chal_base  = '0;
    resp_ready = 1'b0;
    s_start    = 1'b0;
    s_base     = '0;
    s_ready    = 1'b1;
    sat_pa     = 0;
    sat_pb     = 0;
    set_tables(0, 0);

    test_reset();
    test_basic();
    test_tie();
    test_wrap();
    test_hold();
    test_random();
    test_saturate();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
